// File: rtl/lsu_mem_master.sv
// Load/store initiator for a word-addressed data RAM.
// Takes one CPU request at a time, checks alignment, and drives registered RAM
// strobes for WAIT_CYCLES+1 clocks. Returns extended load data or an error flag.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | ready for a request; all mem_* strobes low
//   ACCESS | RAM strobes driven; counter runs down to 0, then data sampled
//   RESP   | resp_valid high, data/err held until resp_ready
module lsu_mem_master #(
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_r,
  output logic [3:0]  mem_w,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_CYCLES);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          we_q;
  logic [2:0]    f3_q;
  logic [1:0]    lane_q;

  logic          accept;
  logic          cnt_done;
  logic          misalign;
  logic [3:0]    st_lanes;
  logic [31:0]   st_data;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_ext;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign accept     = req_valid && (state == IDLE);
  assign cnt_done   = (state == ACCESS) && (cnt == '0);

  // Alignment / legality check; illegal encodings are reported the same way as misalignment.
  always_comb begin
    misalign = 1'b1;
    case (req_funct3)
      3'b000:  misalign = 1'b0;
      3'b001:  misalign = req_addr[0];
      3'b010:  misalign = (req_addr[1:0] != 2'b00);
      3'b100:  misalign = req_we;
      3'b101:  misalign = req_we || req_addr[0];
      default: misalign = 1'b1;
    endcase
  end

  // Byte-lane enables and replicated store data for the incoming request.
  always_comb begin
    st_lanes = 4'b0000;
    st_data  = 32'h0;
    case (req_funct3[1:0])
      2'b00: begin
        st_lanes = 4'b0001 << req_addr[1:0];
        st_data  = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        st_lanes = req_addr[1] ? 4'b1100 : 4'b0011;
        st_data  = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        st_lanes = 4'b1111;
        st_data  = req_wdata;
      end
      default: begin
        st_lanes = 4'b0000;
        st_data  = 32'h0;
      end
    endcase
  end

  // Lane extraction and sign/zero extension of the RAM read word.
  always_comb begin
    ld_byte = 8'h0;
    case (lane_q)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_ext  = 32'h0;
    case (f3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_ext = {24'h0, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_ext = {16'h0, ld_half};
      3'b010:  ld_ext = mem_rdata;
      default: ld_ext = 32'h0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = misalign ? RESP : ACCESS;
      ACCESS:  if (cnt == '0) state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch, wait counter, registered RAM strobes and response data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      we_q       <= 1'b0;
      f3_q       <= 3'b000;
      lane_q     <= 2'b00;
      mem_r      <= 1'b0;
      mem_w      <= 4'b0000;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else if (accept) begin
      we_q       <= req_we;
      f3_q       <= req_funct3;
      lane_q     <= req_addr[1:0];
      cnt        <= CNT_INIT;
      resp_rdata <= 32'h0;
      resp_err   <= misalign;
      if (!misalign) begin
        mem_addr  <= {req_addr[31:2], 2'b00};
        mem_r     <= !req_we;
        mem_w     <= req_we ? st_lanes : 4'b0000;
        mem_wdata <= req_we ? st_data : 32'h0;
      end
    end else if (cnt_done) begin
      mem_r     <= 1'b0;
      mem_w     <= 4'b0000;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      if (!we_q) resp_rdata <= ld_ext;
    end else if (state == ACCESS) begin
      cnt <= cnt - 1'b1;
    end else if (resp_valid && resp_ready) begin
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench: one LSU with no wait states backed by a small RAM model,
// plus one with WAIT_CYCLES=3 fed a fixed read word for timing and reset checks.
module tb_lsu_mem_master;

  logic        clk = 1'b0;
  logic        rst_n;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  logic        req_valid0, req_ready0, req_we0, resp_valid0, resp_ready0, resp_err0, mem_r0;
  logic [2:0]  req_funct3_0;
  logic [31:0] req_addr0, req_wdata0, resp_rdata0, mem_addr0, mem_wdata0, mem_rdata0;
  logic [3:0]  mem_w0;

  logic        req_valid3, req_ready3, req_we3, resp_valid3, resp_ready3, resp_err3, mem_r3;
  logic [2:0]  req_funct3_3;
  logic [31:0] req_addr3, req_wdata3, resp_rdata3, mem_addr3, mem_wdata3, mem_rdata3;
  logic [3:0]  mem_w3;

  logic [31:0] ram [0:63];

  lsu_mem_master #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
    .req_funct3(req_funct3_0), .req_addr(req_addr0), .req_wdata(req_wdata0),
    .resp_valid(resp_valid0), .resp_ready(resp_ready0),
    .resp_rdata(resp_rdata0), .resp_err(resp_err0),
    .mem_r(mem_r0), .mem_w(mem_w0), .mem_addr(mem_addr0),
    .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0)
  );

  lsu_mem_master #(.WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_we(req_we3),
    .req_funct3(req_funct3_3), .req_addr(req_addr3), .req_wdata(req_wdata3),
    .resp_valid(resp_valid3), .resp_ready(resp_ready3),
    .resp_rdata(resp_rdata3), .resp_err(resp_err3),
    .mem_r(mem_r3), .mem_w(mem_w3), .mem_addr(mem_addr3),
    .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3)
  );

  assign mem_rdata0 = ram[mem_addr0[7:2]];
  assign mem_rdata3 = 32'hCAFEF00D;

  // Byte-lane RAM write model for the zero-wait instance.
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (mem_w0[b]) ram[mem_addr0[7:2]][8*b +: 8] <= mem_wdata0[8*b +: 8];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One request on the zero-wait LSU. lat counts posedges from the accepting
  // edge (inclusive) until resp_valid is seen.
  task automatic run0(input logic we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] rd, output logic er,
                      output int lat, output int nr, output int nw,
                      output logic [3:0] wmask, output logic [31:0] maddr,
                      output logic [31:0] mwdata);
    @(negedge clk);
    req_valid0 = 1'b1; req_we0 = we; req_funct3_0 = f3;
    req_addr0 = a; req_wdata0 = wd; resp_ready0 = 1'b1;
    lat = 0; nr = 0; nw = 0; wmask = 4'b0; maddr = 32'h0; mwdata = 32'h0;
    @(posedge clk); #1;
    req_valid0 = 1'b0;
    lat = 1;
    while (!resp_valid0 && lat < 50) begin
      if (mem_r0) begin nr++; maddr = mem_addr0; end
      if (mem_w0 != 4'b0) begin nw++; wmask = mem_w0; maddr = mem_addr0; mwdata = mem_wdata0; end
      @(posedge clk); #1;
      lat++;
    end
    rd = resp_rdata0;
    er = resp_err0;
    @(posedge clk); #1;
  endtask

  task automatic vec(input string tag, input logic we, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_err,
                     input logic [3:0] exp_wmask, input logic [31:0] exp_wdata);
    logic [31:0] rd, maddr, mwdata;
    logic        er;
    int          lat, nr, nw;
    logic [3:0]  wmask;
    run0(we, f3, a, wd, rd, er, lat, nr, nw, wmask, maddr, mwdata);
    chk({tag, "_rdata"}, rd, exp_rd);
    chk({tag, "_err"}, {31'b0, er}, {31'b0, exp_err});
    chk({tag, "_lat"}, lat, exp_err ? 1 : 2);
    chk({tag, "_nr"}, nr, (!we && !exp_err) ? 1 : 0);
    chk({tag, "_nw"}, nw, (we && !exp_err) ? 1 : 0);
    chk({tag, "_wmask"}, {28'b0, wmask}, {28'b0, exp_wmask});
    if (!exp_err) chk({tag, "_maddr"}, maddr, {a[31:2], 2'b00});
    if (we && !exp_err) chk({tag, "_wdata"}, mwdata, exp_wdata);
    chk({tag, "_idle"}, {31'b0, req_ready0}, 32'd1);
  endtask

  initial begin
    int rv_seen, nr3, first_rv, busy_ready;
    for (int i = 0; i < 64; i++) ram[i] = 32'h0;
    rst_n = 1'b0;
    req_valid0 = 0; req_we0 = 0; req_funct3_0 = 0; req_addr0 = 0; req_wdata0 = 0; resp_ready0 = 0;
    req_valid3 = 0; req_we3 = 0; req_funct3_3 = 0; req_addr3 = 0; req_wdata3 = 0; resp_ready3 = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'b0, req_ready0}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid0}, 32'd0);
    chk("rst_mem_r", {31'b0, mem_r0}, 32'd0);
    chk("rst_mem_w", {28'b0, mem_w0}, 32'd0);
    chk("rst_mem_addr", mem_addr0, 32'h0);
    chk("rst_resp", {resp_rdata0[30:0], resp_err0}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    vec("sw10",  1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 4'b1111, 32'hDEADBEEF);
    vec("lw10",  1'b0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 4'b0000, 32'h0);
    vec("sb13",  1'b1, 3'b000, 32'h13, 32'h80,       32'h0,        1'b0, 4'b1000, 32'h80808080);
    vec("lb13",  1'b0, 3'b000, 32'h13, 32'h0,        32'hFFFFFF80, 1'b0, 4'b0000, 32'h0);
    vec("lbu13", 1'b0, 3'b100, 32'h13, 32'h0,        32'h00000080, 1'b0, 4'b0000, 32'h0);
    vec("lb12",  1'b0, 3'b000, 32'h12, 32'h0,        32'hFFFFFFAD, 1'b0, 4'b0000, 32'h0);
    vec("sb11",  1'b1, 3'b000, 32'h11, 32'h1234,     32'h0,        1'b0, 4'b0010, 32'h34343434);
    vec("lw10b", 1'b0, 3'b010, 32'h10, 32'h0,        32'h80AD34EF, 1'b0, 4'b0000, 32'h0);
    vec("sh22",  1'b1, 3'b001, 32'h22, 32'h8001,     32'h0,        1'b0, 4'b1100, 32'h80018001);
    vec("lh22",  1'b0, 3'b001, 32'h22, 32'h0,        32'hFFFF8001, 1'b0, 4'b0000, 32'h0);
    vec("lhu22", 1'b0, 3'b101, 32'h22, 32'h0,        32'h00008001, 1'b0, 4'b0000, 32'h0);
    vec("lh20",  1'b0, 3'b001, 32'h20, 32'h0,        32'h00000000, 1'b0, 4'b0000, 32'h0);
    vec("lw11",  1'b0, 3'b010, 32'h11, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0);
    vec("lh23",  1'b0, 3'b001, 32'h23, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0);
    vec("sw12",  1'b1, 3'b010, 32'h12, 32'h11111111, 32'h0,        1'b1, 4'b0000, 32'h0);
    vec("ld011", 1'b0, 3'b011, 32'h10, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0);
    vec("st100", 1'b1, 3'b100, 32'h10, 32'h55,       32'h0,        1'b1, 4'b0000, 32'h0);
    vec("lw10c", 1'b0, 3'b010, 32'h10, 32'h0,        32'h80AD34EF, 1'b0, 4'b0000, 32'h0);

    // WAIT_CYCLES=3 load with resp_ready held low for the first two RESP cycles.
    @(negedge clk);
    req_valid3 = 1'b1; req_we3 = 1'b0; req_funct3_3 = 3'b010; req_addr3 = 32'h40; resp_ready3 = 1'b0;
    @(posedge clk); #1;
    req_valid3 = 1'b0;
    rv_seen = 0; nr3 = 0; first_rv = -1; busy_ready = 0;
    for (int i = 0; i < 20; i++) begin
      if (rv_seen > 0 && !resp_valid3) break;
      if (mem_r3) nr3++;
      if (req_ready3) busy_ready++;
      if (resp_valid3) begin
        if (first_rv < 0) begin
          first_rv = i;
          chk("w3_rdata", resp_rdata3, 32'hCAFEF00D);
        end
        rv_seen++;
        if (rv_seen == 3) resp_ready3 = 1'b1;
      end
      @(posedge clk); #1;
    end
    chk("w3_mem_r_clks", nr3, 4);
    chk("w3_resp_clks", rv_seen, 3);
    chk("w3_first_resp", first_rv, 4);
    chk("w3_ready_busy", busy_ready, 0);
    chk("w3_ready_end", {31'b0, req_ready3}, 32'd1);

    // Reset asserted while a store is in its ACCESS phase.
    @(negedge clk);
    req_valid3 = 1'b1; req_we3 = 1'b1; req_funct3_3 = 3'b010; req_addr3 = 32'h44;
    req_wdata3 = 32'h12345678; resp_ready3 = 1'b1;
    @(posedge clk); #1;
    req_valid3 = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_mem_w_pre", {28'b0, mem_w3}, 32'hF);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_mem_w", {28'b0, mem_w3}, 32'h0);
    chk("rst_mid_resp_valid", {31'b0, resp_valid3}, 32'd0);
    chk("rst_mid_wdata", mem_wdata3, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_mid_ready", {31'b0, req_ready3}, 32'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("rst_mid_no_resp", {31'b0, resp_valid3}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
